// File: rtl/nx_unpack_pkg.sv
// Shared definitions for the 64->32 FIFO unpack stage: FIFO word layout,
// field offsets, state encoding and a small word-classification helper.
package nx_unpack_pkg;

   localparam int FIFO_DATA_W = 64;
   localparam int FIFO_USER_W = 2;
   localparam int FIFO_NB_W   = 3;
   localparam int FIFO_IN_W   = FIFO_DATA_W + 5 + FIFO_USER_W;

   // Bit positions of each field inside the 71-bit FIFO word
   localparam int DATA_LSB = 0;
   localparam int SOP_BIT  = 64;
   localparam int EOP_BIT  = 65;
   localparam int NB_LSB   = 66;
   localparam int USER_LSB = 69;

   // Packed MSB-first, so the layout matches the offsets above
   typedef struct packed {
      logic [FIFO_USER_W-1:0] user;
      logic [FIFO_NB_W-1:0]   nbm1;   // valid bytes in word minus 1
      logic                   eop;
      logic                   sop;
      logic [FIFO_DATA_W-1:0] data;
   } fifo_word_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LO    = 2'd1,
      HI    = 2'd2
   } unpack_st_e;

   // A closing word carrying at most 4 bytes fits entirely in the low beat
   function automatic logic is_short(input fifo_word_t w);
      return w.eop && (w.nbm1 < 3'd4);
   endfunction

endpackage

// File: rtl/nx_unpack_stats.sv
// Control-plane statistics: accepted-beat counter and packet framing checker.
module nx_unpack_stats
   import nx_unpack_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             pop,       // word taken from the FIFO this cycle
   input  logic             pop_sop,   // sop flag of that word
   input  logic             accept,    // beat handed downstream this cycle
   input  logic             acc_sop,
   input  logic             acc_eop,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             pkt_err
);

   logic in_pkt_q;
   logic in_pkt_now;

   // Framing state including this cycle's accepted beat; a pop coinciding
   // with the closing eop beat must see the packet as already finished.
   always_comb begin
      // NOTE: every signal written in a combinational block gets a default first, otherwise a latch is inferred.
      in_pkt_now = in_pkt_q;
      if (accept) begin
         if (acc_eop)      in_pkt_now = 1'b0;
         else if (acc_sop) in_pkt_now = 1'b1;
      end
   end

   // Beat counter: cleared only by rst, wraps naturally at 2^CNT_W
   always_ff @(posedge clk) begin
      if (rst)         beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + 1'b1;
   end

   // In-packet flag and sticky error; a popped sop must open a packet, any other word must continue one
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         in_pkt_q <= 1'b0;
         pkt_err  <= 1'b0;
      end else begin
         in_pkt_q <= in_pkt_now;
         if (pop && (pop_sop == in_pkt_now)) pkt_err <= 1'b1;
      end
   end

endmodule

// File: rtl/nx_fifo_unpack_64to32.sv
// Drain stage for the 2-deep nx_fifo: pops 64b words and emits them as two
// 32b beats (low half first) on a valid/ready stream, one beat per cycle.
module nx_fifo_unpack_64to32
   import nx_unpack_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int USER_W = 2,
   parameter int CNT_W  = 16,
   parameter int IN_W   = DATA_W + 5 + USER_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                fifo_empty,
   input  logic [IN_W-1:0]     fifo_rdata,
   output logic                fifo_ren,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W/2-1:0] out_data,
   output logic                out_sop,
   output logic                out_eop,
   output logic [1:0]          out_nbytes,
   output logic [USER_W-1:0]   out_user,
   output logic [CNT_W-1:0]    beat_cnt,
   output logic                pkt_err
);

   unpack_st_e state_q, state_d;
   fifo_word_t word_q;
   fifo_word_t pop_word;
   logic       short_w;
   logic       last_beat;
   logic       accept;
   logic       last_acc;

   // Unpack the FIFO head word into its fields
   always_comb begin
      pop_word      = '0;
      pop_word.data = fifo_rdata[DATA_LSB +: FIFO_DATA_W];
      pop_word.sop  = fifo_rdata[SOP_BIT];
      pop_word.eop  = fifo_rdata[EOP_BIT];
      pop_word.nbm1 = fifo_rdata[NB_LSB +: FIFO_NB_W];
      pop_word.user = fifo_rdata[USER_LSB +: FIFO_USER_W];
   end

   assign short_w   = is_short(word_q);
   assign last_beat = (state_q == HI) || ((state_q == LO) && short_w);
   assign accept    = out_valid && out_ready;
   assign last_acc  = accept && last_beat;

   // Pop when idle, or refill in the same cycle the final beat leaves
   assign fifo_ren = !fifo_empty && !rst && !clear && ((state_q == EMPTY) || last_acc);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= EMPTY;
      else     state_q <= state_d;
   end

   // Holding register, loaded on every pop
   always_ff @(posedge clk) begin
      // NOTE: the data register is left unreset; state EMPTY marks it invalid and masks every output.
      if (fifo_ren) word_q <= pop_word;
   end

   // Next state: a pop always restarts at LO, even when it replaces a finishing word
   always_comb begin
      state_d = state_q;
      if (clear)                         state_d = EMPTY;
      else if (fifo_ren)                 state_d = LO;
      else if (last_acc)                 state_d = EMPTY;
      else if (accept && state_q == LO)  state_d = HI;
   end

   // Beat mux driven only from state and the holding register
   always_comb begin
      out_valid  = 1'b0;
      out_data   = '0;
      out_sop    = 1'b0;
      out_eop    = 1'b0;
      out_nbytes = 2'd0;
      out_user   = '0;
      case (state_q)
         LO: begin
            out_valid  = 1'b1;
            out_data   = word_q.data[31:0];
            out_sop    = word_q.sop;
            out_eop    = short_w;
            out_nbytes = short_w ? word_q.nbm1[1:0] : 2'd3;
            out_user   = word_q.user;
         end
         HI: begin
            // An eop word reaching HI has nbm1 >= 4, so nbm1-4 is just its low two bits
            out_valid  = 1'b1;
            out_data   = word_q.data[63:32];
            out_eop    = word_q.eop;
            out_nbytes = word_q.eop ? word_q.nbm1[1:0] : 2'd3;
            out_user   = word_q.user;
         end
         default: ;
      endcase
   end

   nx_unpack_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .pop      (fifo_ren),
      .pop_sop  (pop_word.sop),
      .accept   (accept),
      .acc_sop  (out_sop),
      .acc_eop  (out_eop),
      .beat_cnt (beat_cnt),
      .pkt_err  (pkt_err)
   );

endmodule
